// File: rtl/seg_scan_decoder.sv
// Passive decoder for the stopwatch seven-segment scan: waits for each digit
// phase to settle, decodes it, and rebuilds min/sec from complete 4-digit frames.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] anode_vec,
    input  logic [6:0] cathode_vec,
    input  logic       err_clr,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       frame_valid,
    output logic [3:0] blank_mask,
    output logic       seg_err,
    output logic       anode_err,
    output logic       range_err
);

    localparam logic [7:0] CNT_SAT = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT
    } state_t;

    logic [3:0]  a_q;
    logic [6:0]  c_q;
    logic [10:0] prev_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        changed;
    logic        stb_q;
    logic        stb_d;
    logic [3:0]  cap_a_q;
    logic [6:0]  cap_c_q;

    state_t      state_q;
    logic [3:0]  seen_q;
    logic [3:0]  seen_d;
    logic [3:0]  blk_q;
    logic [3:0]  blk_d;
    logic [3:0]  dig_q [4];
    logic [3:0]  dig_d [4];

    logic [5:0]  min_q;
    logic [5:0]  sec_q;
    logic        frame_valid_q;
    logic [3:0]  blank_mask_q;
    logic        seg_err_q;
    logic        anode_err_q;
    logic        range_err_q;

    logic        dec_digit;
    logic        dec_blank;
    logic [3:0]  dec_val;
    logic [1:0]  pos;
    logic        one_lit;
    logic        none_lit;
    logic        cap_hit;
    logic        seg_set;
    logic        anode_set;
    logic [3:0]  hit_mask;
    logic        frame_done;
    logic        tens_bad;
    logic        range_set;
    logic [5:0]  min_d;
    logic [5:0]  sec_d;

    assign changed = ({a_q, c_q} != prev_q);

    // Strobe is raised in the cycle the count first lands on STABLE_CYCLES.
    always_comb begin
        cnt_d = cnt_q;
        stb_d = 1'b0;
        if (changed) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 8'd1;
            end
            stb_d = (cnt_q == CNT_PRE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '1;
            c_q     <= '1;
            prev_q  <= '1;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            cap_a_q <= '1;
            cap_c_q <= '1;
        end else begin
            a_q    <= anode_vec;
            c_q    <= cathode_vec;
            prev_q <= {a_q, c_q};
            cnt_q  <= cnt_d;
            stb_q  <= stb_d;
            if (stb_d) begin
                cap_a_q <= a_q;
                cap_c_q <= c_q;
            end
        end
    end

    always_comb begin
        dec_digit = 1'b1;
        dec_blank = 1'b0;
        dec_val   = '0;
        case (cap_c_q)
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0010000: dec_val = 4'd9;
            7'b1111111: begin
                dec_digit = 1'b0;
                dec_blank = 1'b1;
            end
            default:    dec_digit = 1'b0;
        endcase
    end

    always_comb begin
        pos     = '0;
        one_lit = 1'b1;
        case (cap_a_q)
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            default: one_lit = 1'b0;
        endcase
    end

    assign none_lit  = &cap_a_q;
    assign cap_hit   = stb_q & one_lit & (dec_digit | dec_blank);
    assign seg_set   = stb_q & one_lit & ~dec_digit & ~dec_blank;
    assign anode_set = stb_q & ~one_lit & ~none_lit;
    assign hit_mask  = cap_hit ? (4'b0001 << pos) : 4'b0000;

    always_comb begin
        seen_d = seen_q | hit_mask;
        blk_d  = (blk_q & ~hit_mask) | (dec_blank ? hit_mask : 4'b0000);
        dig_d  = dig_q;
        if (cap_hit && dec_digit) begin
            dig_d[pos] = dec_val;
        end
    end

    // A blanked tens digit holds a stale value, so it is excluded from the range check.
    assign frame_done = (state_q == COLLECT) && (seen_q == 4'hF);
    assign tens_bad   = (!blk_q[3] && (dig_q[3] > 4'd5)) || (!blk_q[1] && (dig_q[1] > 4'd5));
    assign range_set  = frame_done & tens_bad;
    assign min_d      = 6'(dig_q[3]) * 6'd10 + 6'(dig_q[2]);
    assign sec_d      = 6'(dig_q[1]) * 6'd10 + 6'(dig_q[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            seen_q        <= '0;
            blk_q         <= '0;
            dig_q         <= '{default: '0};
            min_q         <= '0;
            sec_q         <= '0;
            frame_valid_q <= 1'b0;
            blank_mask_q  <= '0;
            seg_err_q     <= 1'b0;
            anode_err_q   <= 1'b0;
            range_err_q   <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            seg_err_q     <= seg_set | (seg_err_q & ~err_clr);
            anode_err_q   <= anode_set | (anode_err_q & ~err_clr);
            range_err_q   <= range_set | (range_err_q & ~err_clr);
            seen_q        <= seen_d;
            blk_q         <= blk_d;
            dig_q         <= dig_d;
            case (state_q)
                IDLE: begin
                    if (cap_hit) begin
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (frame_done) begin
                        state_q       <= EMIT;
                        frame_valid_q <= 1'b1;
                        blank_mask_q  <= blk_q;
                        if ((blk_q == 4'b0000) && !tens_bad) begin
                            min_q <= min_d;
                            sec_q <= sec_d;
                        end
                        // Frame storage restarts here so a capture in EMIT lands in the next frame.
                        seen_q <= hit_mask;
                        blk_q  <= dec_blank ? hit_mask : 4'b0000;
                    end
                end
                EMIT: begin
                    state_q <= COLLECT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign min         = min_q;
    assign sec         = sec_q;
    assign frame_valid = frame_valid_q;
    assign blank_mask  = blank_mask_q;
    assign seg_err     = seg_err_q;
    assign anode_err   = anode_err_q;
    assign range_err   = range_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scan frames plus randomized dwells,
// scored against a dwell-level reference model of the decoder.
module tb_seg_scan_decoder;

    localparam int S = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] anode_vec;
    logic [6:0] cathode_vec;
    logic       err_clr;
    logic [5:0] min;
    logic [5:0] sec;
    logic       frame_valid;
    logic [3:0] blank_mask;
    logic       seg_err;
    logic       anode_err;
    logic       range_err;

    seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .anode_vec   (anode_vec),
        .cathode_vec (cathode_vec),
        .err_clr     (err_clr),
        .min         (min),
        .sec         (sec),
        .frame_valid (frame_valid),
        .blank_mask  (blank_mask),
        .seg_err     (seg_err),
        .anode_err   (anode_err),
        .range_err   (range_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int mn;
        int sc;
        int bm;
    } frame_t;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int     m_dig [4];
    bit     m_seen [4];
    bit     m_blk [4];
    int     m_min, m_sec;
    bit     m_seg, m_an, m_rng;
    frame_t exp_q [$];
    int     frames_exp;
    int     frames_seen;
    logic [10:0] last_pat;
    int     run_len;
    bit     run_cap;

    function automatic int seg_value(input logic [6:0] c);
        if (c == 7'h7F) return 10;
        for (int i = 0; i < 10; i++) if (seg_tab[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_dig[i] = 0; m_seen[i] = 0; m_blk[i] = 0;
        end
        m_min = 0; m_sec = 0;
        m_seg = 0; m_an = 0; m_rng = 0;
        last_pat = 11'h7FF; run_len = 0; run_cap = 1;
    endtask

    task automatic model_frame();
        frame_t f;
        int bm;
        bit bad;
        bm = 0;
        for (int i = 0; i < 4; i++) if (m_blk[i]) bm += (1 << i);
        bad = (!m_blk[3] && m_dig[3] > 5) || (!m_blk[1] && m_dig[1] > 5);
        if (bad) m_rng = 1;
        else if (bm == 0) begin
            m_min = m_dig[3] * 10 + m_dig[2];
            m_sec = m_dig[1] * 10 + m_dig[0];
        end
        f.mn = m_min; f.sc = m_sec; f.bm = bm;
        exp_q.push_back(f);
        frames_exp++;
        for (int i = 0; i < 4; i++) begin
            m_seen[i] = 0; m_blk[i] = 0;
        end
    endtask

    task automatic model_capture(input logic [3:0] a, input logic [6:0] c);
        int zeros, k, v;
        zeros = 0; k = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; k = i; end
        if (zeros == 0) return;
        if (zeros > 1) begin m_an = 1; return; end
        v = seg_value(c);
        if (v < 0) begin m_seg = 1; return; end
        m_seen[k] = 1;
        m_blk[k]  = (v == 10);
        if (v < 10) m_dig[k] = v;
        if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) model_frame();
    endtask

    // Each call holds one pattern for n clock edges; equal neighbours form one dwell.
    task automatic dwell(input logic [3:0] a, input logic [6:0] c, input int n);
        anode_vec   = a;
        cathode_vec = c;
        if ({a, c} == last_pat) run_len += n;
        else begin
            last_pat = {a, c}; run_len = n; run_cap = 0;
        end
        if (!run_cap && run_len >= S + 1) begin
            run_cap = 1;
            model_capture(a, c);
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        dwell(4'hF, 7'h7F, S + 8);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_seg"},   seg_err,   m_seg);
        check({tag, "_anode"}, anode_err, m_an);
        check({tag, "_range"}, range_err, m_rng);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_seg = 0; m_an = 0; m_rng = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        anode_vec = 4'hF; cathode_vec = 7'h7F; err_clr = 1'b0;
        #2;
        model_reset();
        check("rst_min", min, 0);
        check("rst_sec", sec, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_blank", blank_mask, 0);
        check_flags("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        frame_t f;
        if (rst_n === 1'b1 && frame_valid === 1'b1) begin
            frames_seen++;
            if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
            else begin
                f = exp_q.pop_front();
                check("frame_min", min, f.mn);
                check("frame_sec", sec, f.sc);
                check("frame_blank", blank_mask, f.bm);
            end
        end
    end

    task automatic rand_frame();
        int order [4];
        int j, t, r, d;
        logic [3:0] a;
        logic [6:0] c;
        for (int i = 0; i < 4; i++) order[i] = i;
        for (int i = 3; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 4; i++) begin
            a = ~(4'b0001 << order[i]);
            r = $urandom_range(99, 0);
            if (r < 80) begin
                if ((order[i] == 1 || order[i] == 3) && $urandom_range(9, 0) != 0)
                    c = seg_tab[$urandom_range(5, 0)];
                else
                    c = seg_tab[$urandom_range(9, 0)];
            end else if (r < 88) begin
                c = 7'h7F;
            end else if (r < 93) begin
                do c = 7'($urandom); while (seg_value(c) != -1);
            end else if (r < 97) begin
                do a = 4'($urandom); while ($countones(~a) < 2);
                c = seg_tab[$urandom_range(9, 0)];
            end else begin
                a = 4'hF;
                c = seg_tab[$urandom_range(9, 0)];
            end
            d = ($urandom_range(3, 0) == 0) ? $urandom_range(S + 1, S - 3) : $urandom_range(S + 6, S + 1);
            dwell(a, c, d);
        end
    endtask

    int base;

    initial begin
        frames_exp = 0;
        frames_seen = 0;
        apply_reset();

        // 01:25, scan order not aligned to position
        dwell(4'b1101, 7'h24, 20);
        dwell(4'b1110, 7'h12, 20);
        dwell(4'b0111, 7'h40, 20);
        dwell(4'b1011, 7'h79, 20);
        settle();
        check("f125_count", frames_seen, 1);
        check("f125_min", min, 1);
        check("f125_sec", sec, 25);
        check("f125_blank", blank_mask, 0);
        check_flags("f125");

        // minutes blanked: values hold
        dwell(4'b1101, 7'h24, 20);
        dwell(4'b1110, 7'h12, 20);
        dwell(4'b0111, 7'h7F, 20);
        dwell(4'b1011, 7'h7F, 20);
        settle();
        check("blank_count", frames_seen, 2);
        check("blank_mask", blank_mask, 4'b1100);
        check("blank_min", min, 1);
        check("blank_sec", sec, 25);

        // dwell length boundary on the completing digit
        dwell(4'b1101, 7'h24, 20);
        dwell(4'b1110, 7'h12, 20);
        dwell(4'b0111, 7'h40, 20);
        dwell(4'b1011, 7'h79, S);
        settle();
        check("dwell16_count", frames_seen, 2);
        dwell(4'b1011, 7'h79, S + 1);
        settle();
        check("dwell17_count", frames_seen, 3);

        // anode and segment errors, then clear
        dwell(4'b0011, 7'h40, 20);
        settle();
        check("anode_err_set", anode_err, 1);
        check("anode_err_noseg", seg_err, 0);
        dwell(4'b1110, 7'h55, 20);
        settle();
        check("seg_err_set", seg_err, 1);
        clear_errors();
        check("clr_seg", seg_err, 0);
        check("clr_anode", anode_err, 0);

        // seconds tens of 7
        dwell(4'b0111, 7'h40, 20);
        dwell(4'b1011, 7'h79, 20);
        dwell(4'b1101, 7'h78, 20);
        dwell(4'b1110, 7'h12, 20);
        settle();
        check("range_count", frames_seen, 4);
        check("range_err_set", range_err, 1);
        check("range_sec_hold", sec, 25);
        check("range_min_hold", min, 1);
        clear_errors();
        check_flags("range_clr");

        // reset in the middle of a frame
        dwell(4'b0111, 7'h12, 20);
        dwell(4'b1011, 7'h10, 20);
        apply_reset();
        base = frames_seen;
        dwell(4'b0111, 7'h12, 20);
        dwell(4'b1011, 7'h10, 20);
        dwell(4'b1101, 7'h12, 20);
        dwell(4'b1110, 7'h10, 20);
        settle();
        check("rst_frame_count", frames_seen - base, 1);
        check("f5959_min", min, 59);
        check("f5959_sec", sec, 59);

        // randomized dwells, patterns and errors
        for (int g = 0; g < 8; g++) begin
            for (int f = 0; f < 5; f++) rand_frame();
            settle();
            check_flags("rand");
            check("rand_min", min, m_min);
            check("rand_sec", sec, m_sec);
            clear_errors();
        end

        check("frame_total", frames_seen, frames_exp);
        check("frames_pending", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the stopwatch seven-segment driver: watches the multiplexed `anode_vec`/`cathode_vec` lines, waits for each digit phase to settle, decodes the segment pattern back to a BCD digit, and reassembles complete 4-digit frames into binary `min`/`sec` values. It sits beside the display path, on the same system clock as the stopwatch top. It is used for self-check and bench scoreboarding, and it flags blanked (blinking) digits and malformed patterns.

## Interface
- `STABLE_CYCLES`, default 16: consecutive unchanged cycles of `{anode_vec, cathode_vec}` required before a digit phase is sampled. Legal range 2..255.
- `clk  in  1`: system clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `anode_vec  in  4`: active-low digit enables.
  - bit3 = minutes tens, bit2 = minutes ones, bit1 = seconds tens, bit0 = seconds ones.
- `cathode_vec  in  7`: active-low segments, bit order {g,f,e,d,c,b,a}.
- `err_clr  in  1`: synchronous clear of the sticky error flags.
- `min  out  6`: decoded minutes (0..59).
- `sec  out  6`: decoded seconds (0..59).
- `frame_valid  out  1`: one-cycle pulse when a frame completes.
- `blank_mask  out  4`: per-digit blank flags for the last completed frame.
- `seg_err  out  1`: sticky; unrecognised segment pattern.
- `anode_err  out  1`: sticky; more than one anode low.
- `range_err  out  1`: sticky; a tens digit is above 5.

## Operation
- Input register: one register stage on `anode_vec` and `cathode_vec`. All logic uses the registered copies (`a_q`, `c_q`).
- Stability counter, 8 bits:
  - Clears to 0 when `{a_q, c_q}` differs from the previous cycle; otherwise increments and saturates at `STABLE_CYCLES`.
  - A capture strobe fires only in the cycle the count first reaches `STABLE_CYCLES`, so there is one strobe per dwell.
- On a capture strobe, classify `a_q`:
  - All ones: no digit is lit; ignore.
  - Exactly one zero at position k: decode `c_q`.
  - Two or more zeros: set `anode_err` and capture nothing.
- Segment decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 1111111 = blank.
  - Any other pattern: set `seg_err` and do not mark position k.
  - Valid digit: `dig[k]` = value, `seen[k]` = 1, `blk[k]` = 0.
  - Blank: `seen[k]` = 1, `blk[k]` = 1; `dig[k]` is unchanged.
  - A repeated position within one frame overwrites the earlier value. The decoder does not assume any scan order.
- FSM states:
  - IDLE: after reset. Moves to COLLECT on the first valid or blank capture.
  - COLLECT: moves to EMIT in the cycle after `seen` becomes 4'hF.
  - EMIT: lasts one cycle, then returns to COLLECT with `seen` cleared.
- In EMIT:
  - Always: pulse `frame_valid` and set `blank_mask` = `blk`.
  - If `blk` == 0 and both tens digits are ≤ 5: `min` = dig3·10 + dig2 and `sec` = dig1·10 + dig0, each 6 bits. The max of 59 fits.
  - If either tens digit is > 5: set `range_err` and hold `min`/`sec`.
  - If any `blk` bit is set: hold `min`/`sec`, but still emit the frame.
- `err_clr` clears all three sticky flags. If a new error and `err_clr` occur in the same cycle, the error wins and its flag stays set.

## Timing
- Reset values: `min` = 0, `sec` = 0, `frame_valid` = 0, `blank_mask` = 0, all error flags = 0. Internal state: state = IDLE, `seen` = 0, `blk` = 0, `dig` = 0, counter = 0.
- Reset is asynchronous and may arrive mid-frame. The partial frame is discarded, and there is no `frame_valid` until four fresh captures complete.
- Capture latency:
  - The input changes at cycle t. `a_q`/`c_q` update at t+1.
  - The capture strobe is registered at t+`STABLE_CYCLES`+1. A dwell shorter than `STABLE_CYCLES`+1 cycles is never captured.
- Frame latency: `frame_valid` and the new `min`/`sec` appear 1 cycle after the capture that completes `seen`.
- If a capture strobe falls in the EMIT cycle, it is applied to the next frame's `seen`/`dig`. It is not lost.
- Error flags assert the cycle after the offending capture strobe.

## Test plan
- Reset, then scan 1101/0100100, 1110/0010010, 0111/1000000, 1011/1111001, each dwelling 20 cycles -> `frame_valid` pulse, `min` = 1, `sec` = 25, `blank_mask` = 0000.
- Same frame, but positions 3 and 2 show 1111111 -> `frame_valid` pulses, `blank_mask` = 1100, `min`/`sec` hold their previous values.
- Dwell of `STABLE_CYCLES` cycles (16), i.e. less than 17 -> no capture and no `frame_valid`. Dwell of 17 -> exactly one capture.
- `anode_vec` = 0011 held stable -> `anode_err` = 1, no capture. `cathode_vec` = 1010101 on a single anode -> `seg_err` = 1. Assert `err_clr` -> both flags clear the next cycle.
- Seconds-tens pattern for 7 (1111000) in a full frame -> `range_err` = 1, `frame_valid` pulses, `sec` unchanged.
- Assert `rst_n` low after two of four captures, release, then send a full frame of 59:59 -> exactly one `frame_valid`, `min` = 59, `sec` = 59.
